// File: rtl/service_mode_ctrl.sv
// Service-mode arbiter: grants one of three services from the select switches and routes push/display.
// Optional push_m debounce is enabled by defining SERVICE_MODE_CTRL_DEBOUNCE_EN.
module service_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned FINISH_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  spdt,
  input  logic        push_m,
  input  logic [15:0] seg_in1,
  input  logic [15:0] seg_in2,
  input  logic [15:0] seg_in3,
  input  logic [2:0]  finish,
  output logic [2:0]  svc_en,
  output logic [2:0]  svc_push,
  output logic [15:0] segments,
  output logic        conflict_led,
  output logic        timeout_err,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_GRANT    = 3'b001,
    ST_RUN      = 3'b010,
    ST_DRAIN    = 3'b011,
    ST_CONFLICT = 3'b100
  } state_e;

  localparam int unsigned CNT_W =
    ($clog2(FINISH_TIMEOUT + 1) > 8) ? $clog2(FINISH_TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((FINISH_TIMEOUT > 0) ? FINISH_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic [15:0]      segments_q, segments_d;
  logic [2:0]       svc_push_q, svc_push_d;

  logic [2:0] spdt_s1_q, spdt_s2_q;
  logic       push_s1_q, push_s2_q;
  logic       push_prev_q;
  logic       push_level;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spdt_s1_q <= '0;
      spdt_s2_q <= '0;
      push_s1_q <= 1'b0;
      push_s2_q <= 1'b0;
    end else begin
      spdt_s1_q <= spdt;
      spdt_s2_q <= spdt_s1_q;
      push_s1_q <= push_m;
      push_s2_q <= push_s1_q;
    end
  end

`ifdef SERVICE_MODE_CTRL_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            push_db_q, push_db_d;

  // The filtered level only follows the synced button after it has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    db_cnt_d  = '0;
    push_db_d = push_db_q;
    if (push_s2_q != push_db_q) begin
      if (db_cnt_q >= DB_LAST) push_db_d = push_s2_q;
      else                     db_cnt_d  = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      db_cnt_q  <= '0;
      push_db_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      push_db_q <= push_db_d;
    end
  end

  assign push_level = push_db_q;
`else
  assign push_level = push_s2_q;
`endif

  logic [1:0] spdt_cnt;
  logic [1:0] spdt_idx;
  logic [2:0] owner_onehot;
  logic       push_rise;

  assign spdt_cnt     = 2'(spdt_s2_q[0]) + 2'(spdt_s2_q[1]) + 2'(spdt_s2_q[2]);
  assign spdt_idx     = spdt_s2_q[0] ? 2'd0 : (spdt_s2_q[1] ? 2'd1 : 2'd2);
  assign owner_onehot = 3'b001 << owner_q;
  assign push_rise    = push_level & ~push_prev_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (spdt_cnt == 2'd1) begin
          state_d = ST_GRANT;
          owner_d = spdt_idx;
        end else if (spdt_cnt >= 2'd2) begin
          state_d = ST_CONFLICT;
        end
      end
      ST_GRANT: begin
        state_d       = ST_RUN;
        timeout_err_d = 1'b0;
      end
      ST_RUN: begin
        // Only the owner's own switch ends the session; other switches cannot preempt.
        if (!spdt_s2_q[owner_q]) begin
          state_d   = ST_DRAIN;
          tmo_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        tmo_cnt_d = (tmo_cnt_q == CNT_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        if (finish[owner_q]) begin
          state_d = ST_IDLE;
        end else if (tmo_cnt_q >= TMO_LAST) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end
      end
      ST_CONFLICT: begin
        if (spdt_cnt <= 2'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    svc_push_d = '0;
    if (state_q == ST_RUN && push_rise) svc_push_d = owner_onehot;

    segments_d = 16'h0000;
    unique case (state_q)
      ST_GRANT, ST_RUN, ST_DRAIN: begin
        unique case (owner_q)
          2'd0:    segments_d = seg_in1;
          2'd1:    segments_d = seg_in2;
          default: segments_d = seg_in3;
        endcase
      end
      ST_CONFLICT: segments_d = 16'hEEEE;
      default:     segments_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      owner_q       <= 2'd0;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      segments_q    <= 16'h0000;
      svc_push_q    <= '0;
      push_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
      segments_q    <= segments_d;
      svc_push_q    <= svc_push_d;
      push_prev_q   <= push_level;
    end
  end

  // Grant decodes straight from the state register so an async reset drops it at once.
  always_comb begin
    svc_en = '0;
    if (state_q == ST_GRANT || state_q == ST_RUN || state_q == ST_DRAIN) svc_en = owner_onehot;
  end

  assign svc_push     = svc_push_q;
  assign segments     = segments_q;
  assign conflict_led = (state_q == ST_CONFLICT);
  assign timeout_err  = timeout_err_q;
  assign state_o      = state_q;

endmodule

// File: doc/service_mode_ctrl.md
SERVICE_MODE_CTRL -- requirements
Module: service_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, push_m stable-cycles required before acceptance (10 ms at 100 MHz).
REQ-002 Parameter FINISH_TIMEOUT, default 255, max DRAIN cycles waiting for finish.
REQ-003 clk  in  1  single system clock, rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 spdt  in  3  raw service-select switches; bit i selects service i+1.
REQ-006 push_m  in  1  raw shared push button.
REQ-007 seg_in1, seg_in2, seg_in3  in  16 each  BCD display words from services 1..3.
REQ-008 finish  in  3  per-service finish flags (level).
REQ-009 svc_en  out  3  one-hot service grant.
REQ-010 svc_push  out  3  one-cycle push pulse routed to the granted service only.
REQ-011 segments  out  16  shared 4-digit BCD display word.
REQ-012 conflict_led  out  1  high while in CONFLICT.
REQ-013 timeout_err  out  1  sticky finish-timeout flag.
REQ-014 state_o  out  3  current state encoding, debug.

Function
REQ-015 spdt and push_m SHALL each pass a 2-flop synchronizer before use.
REQ-016 FSM states: IDLE=000, GRANT=001, RUN=010, DRAIN=011, CONFLICT=100; state_o SHALL equal the state register.
REQ-017 IDLE: exactly one synced spdt bit high -> GRANT, owner latched; two or more high -> CONFLICT; none -> stay.
REQ-018 GRANT lasts exactly one cycle, sets svc_en[owner]=1, clears timeout_err, then -> RUN.
REQ-019 RUN: svc_en[owner] held; owner's spdt low -> DRAIN; other spdt bits ignored, no preemption.
REQ-020 DRAIN: svc_en[owner] held, timeout counter increments each cycle; finish[owner]=1 -> IDLE, svc_en cleared on the transition edge.
REQ-021 DRAIN with counter reaching FINISH_TIMEOUT and no finish -> IDLE, timeout_err set to 1.
REQ-022 finish and owner-switch-off in the same cycle during RUN: -> DRAIN, then IDLE one cycle later; no shortcut.
REQ-023 CONFLICT: svc_en=0, conflict_led=1; synced spdt popcount <=1 -> IDLE, and regrant proceeds via IDLE.
REQ-024 Push edge detect: svc_push[owner] SHALL pulse for exactly one cycle per accepted rising edge, only in RUN; pushes in other states are discarded, not queued.
REQ-025 Without debounce, the svc_push pulse SHALL appear 3 clk edges after push_m is first sampled high; holding push_m produces a single pulse.
REQ-026 segments registered (1-cycle latency): IDLE 16'h0000; GRANT/RUN/DRAIN seg_in of owner; CONFLICT 16'hEEEE.
REQ-027 Timeout counter 8 bits minimum, saturating, cleared on DRAIN entry.

Reset
REQ-028 resetn low SHALL asynchronously force: state IDLE, owner 0, svc_en 0, svc_push 0, segments 16'h0000, conflict_led 0, timeout_err 0, synchronizers/counters 0.
REQ-029 resetn asserted mid-RUN or mid-DRAIN SHALL drop svc_en immediately; after release the FSM re-evaluates from IDLE.

Configuration
REQ-030 Macro SERVICE_MODE_CTRL_DEBOUNCE_EN defined: synced push_m must remain at its new level for DEBOUNCE_CYCLES consecutive cycles before the edge detector sees it; glitches shorter than that produce no pulse.
REQ-031 Macro undefined: no debounce counter; synchronizer output feeds the edge detector directly (REQ-025 latency).

Verification (DEBOUNCE_CYCLES=4 for sim)
REQ-032 spdt=3'b100 from IDLE -> GRANT 1 cycle, svc_en=3'b100, segments=seg_in3 one cycle after RUN entry.
REQ-033 RUN owner 3, push_m high 10 cycles -> exactly one svc_push=3'b100 pulse; svc_push[1:0] stay 0.
REQ-034 spdt=3'b011 from IDLE -> CONFLICT, conflict_led=1, segments=16'hEEEE; spdt->3'b001 -> IDLE -> GRANT, svc_en=3'b001.
REQ-035 RUN owner 1, spdt[0] low, finish[0] never asserted -> IDLE after 255 DRAIN cycles, timeout_err=1; next GRANT clears it.
REQ-036 RUN owner 2, resetn pulsed low mid-cycle -> svc_en=0 and segments=0 without waiting for clk.
REQ-037 DEBOUNCE_EN defined, push_m high 2 cycles -> no pulse; high 6 cycles -> one pulse.
